// File: rtl/automata_pkg.sv
// Shared types for the programmable automata engine: STE start codes and
// config-port write types.
package automata_pkg;

    typedef enum logic [1:0] {
        START_NONE = 2'd0,
        START_SOD  = 2'd1,
        START_ALL  = 2'd2
    } start_e;

    typedef enum logic [1:0] {
        CFG_CLASS  = 2'd0,
        CFG_EDGE   = 2'd1,
        CFG_START  = 2'd2,
        CFG_REPORT = 2'd3
    } cfg_type_e;

    localparam int DEFAULT_SYM_W = 8;
    localparam int CLASS_DEPTH   = 2 ** DEFAULT_SYM_W;

endpackage

// File: rtl/automata_report_fifo.sv
// First-word-fall-through report FIFO; head data reads as zero while empty.
module automata_report_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign head_valid = (count != '0);
    assign full       = (count == (AW+1)'(DEPTH));
    assign head_data  = head_valid ? mem[rd_ptr] : '0;
    assign push_ok    = push & ~full;
    assign pop_ok     = pop & head_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/automata_engine_prog.sv
// Runtime-programmable homogeneous automata engine: N_STE generic STEs with
// config-loaded symbol classes, adjacency, start types and report flags.
module automata_engine_prog
    import automata_pkg::*;
#(
    parameter int N_STE      = 16,
    parameter int SYM_W      = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int OFS_W      = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SYM_W-1:0]         in_symbol,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_type,
    input  logic [$clog2(N_STE)-1:0] cfg_ste,
    input  logic [SYM_W-1:0]         cfg_idx,
    input  logic                     cfg_bit,
    output logic                     rpt_valid,
    input  logic                     rpt_ready,
    output logic [N_STE-1:0]         rpt_vector,
    output logic [OFS_W-1:0]         rpt_offset,
    output logic                     busy
);

    localparam int STE_W  = $clog2(N_STE);
    localparam int CDEPTH = 2 ** SYM_W;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic                engine_state;
    logic [CDEPTH-1:0]   class_mem  [N_STE];
    logic [N_STE-1:0]    adj        [N_STE];   // adj[i][j]: edge j -> i
    start_e              start_code [N_STE];
    logic [N_STE-1:0]    report_en;
    logic [N_STE-1:0]    active;
    logic [N_STE-1:0]    next_active;
    logic [N_STE-1:0]    rpt_mask;
    logic [OFS_W-1:0]    offset;
    logic                sod_armed;
    logic                accept;
    logic                fifo_full;
    logic                fifo_push;
    logic [N_STE+OFS_W-1:0] fifo_head;

    // Run has no internal sequencing, so the control state simply mirrors it;
    // dropping run freezes active/offset because nothing is accepted.
    assign engine_state = run ? ST_RUN : ST_IDLE;

    assign in_ready  = (engine_state == ST_RUN) & ~fifo_full & ~flush & ~reset;
    assign accept    = in_valid & in_ready;
    assign busy      = run | rpt_valid;

    always_comb begin
        next_active = '0;
        for (int unsigned i = 0; i < N_STE; i++) begin
            next_active[i] = ((start_code[i] == START_ALL)
                             | ((start_code[i] == START_SOD) & sod_armed)
                             | (|(active & adj[i])))
                             & class_mem[i][in_symbol];
        end
    end

    assign rpt_mask  = next_active & report_en;
    assign fifo_push = accept & (|rpt_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_STE; i++) begin
                class_mem[i]  <= '0;
                adj[i]        <= '0;
                start_code[i] <= START_NONE;
            end
            report_en <= '0;
        end else if (cfg_we && !run) begin
            case (cfg_type_e'(cfg_type))
                CFG_CLASS:  class_mem[cfg_ste][cfg_idx] <= cfg_bit;
                CFG_EDGE: begin
                    if (32'(cfg_idx) < N_STE) begin
                        adj[cfg_ste][cfg_idx[STE_W-1:0]] <= cfg_bit;
                    end
                end
                CFG_START:  start_code[cfg_ste] <= start_e'(cfg_idx[1:0]);
                CFG_REPORT: report_en[cfg_ste]  <= cfg_bit;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            active    <= '0;
            offset    <= '0;
            sod_armed <= 1'b1;
        end else if (accept) begin
            active    <= next_active;
            offset    <= offset + 1'b1;
            sod_armed <= 1'b0;
        end
    end

    automata_report_fifo #(
        .WIDTH(N_STE + OFS_W),
        .DEPTH(FIFO_DEPTH)
    ) u_report_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({rpt_mask, offset}),
        .pop       (rpt_valid & rpt_ready),
        .full      (fifo_full),
        .head_valid(rpt_valid),
        .head_data (fifo_head)
    );

    assign rpt_vector = fifo_head[OFS_W +: N_STE];
    assign rpt_offset = fifo_head[OFS_W-1:0];

endmodule
